// File: rtl/rv32i_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_multicycle_control_fsm
// Brief    : Main control state machine of the multicycle RV32I core.
//            Sequences each instruction through fetch, decode, execute,
//            memory and writeback. Drives datapath mux selects, write
//            enables and the 2-bit ALUOp for the ALU decoder.
// Ports    : clk         - system clock, rising-edge active
//            rst_n       - synchronous active-low reset
//            op          - opcode field of the instruction register
//            zero        - ALU zero flag (branch condition)
//            mem_ready   - memory access completes this cycle
//            pc_write    - PC register write enable
//            adr_src     - memory address select (0 PC, 1 ALUOut)
//            mem_write   - data memory write strobe
//            ir_write    - instruction register / OldPC load enable
//            result_src  - result mux (00 ALUOut, 01 Data, 10 ALUResult)
//            alu_src_a   - SrcA mux (00 PC, 01 OldPC, 10 rs1)
//            alu_src_b   - SrcB mux (00 rs2, 01 imm, 10 constant 4)
//            alu_op      - ALUOp (00 add, 01 subtract, 10 funct-decoded)
//            reg_write   - register file write enable
//            imm_src     - immediate format select
//            instr_done  - one-cycle pulse on instruction retirement
//            illegal_op  - unsupported opcode flag
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_multicycle_control_fsm #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] imm_src,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef logic [3:0] state_t;

    localparam state_t c_FETCH    = 4'd0;
    localparam state_t c_DECODE   = 4'd1;
    localparam state_t c_MEMADR   = 4'd2;
    localparam state_t c_MEMREAD  = 4'd3;
    localparam state_t c_MEMWB    = 4'd4;
    localparam state_t c_MEMWRITE = 4'd5;
    localparam state_t c_EXECUTER = 4'd6;
    localparam state_t c_EXECUTEI = 4'd7;
    localparam state_t c_ALUWB    = 4'd8;
    localparam state_t c_BEQ      = 4'd9;
    localparam state_t c_JAL      = 4'd10;
    localparam state_t c_ERROR    = 4'd11;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    state_t r_state;
    state_t w_next_state;

    // State register. Reset wins over everything, including the halted
    // ERROR state, so it is also what clears a sticky illegal_op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_next_state = r_state;
        pc_write     = 1'b0;
        adr_src      = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        result_src   = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        reg_write    = 1'b0;
        imm_src      = 2'b00;
        instr_done   = 1'b0;
        illegal_op   = 1'b0;

        // Immediate format follows the opcode regardless of state.
        case (op)
            c_OP_STORE:  imm_src = 2'b01;
            c_OP_BRANCH: imm_src = 2'b10;
            c_OP_JAL:    imm_src = 2'b11;
            default:     imm_src = 2'b00;
        endcase

        case (r_state)
            c_FETCH: begin
                // PC+4 computed through the ALU and written back unlatched
                // (ALUResult) so the PC updates in the same cycle as IR.
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    w_next_state = c_DECODE;
                end
            end
            c_DECODE: begin
                // OldPC + imm: branch target ready in ALUOut for BEQ.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    c_OP_LOAD,
                    c_OP_STORE:  w_next_state = c_MEMADR;
                    c_OP_RTYPE:  w_next_state = c_EXECUTER;
                    c_OP_ITYPE:  w_next_state = c_EXECUTEI;
                    c_OP_BRANCH: w_next_state = c_BEQ;
                    c_OP_JAL:    w_next_state = c_JAL;
                    default:     w_next_state = c_ERROR;
                endcase
            end
            c_MEMADR: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                // op[5] separates store (0100011) from load (0000011).
                w_next_state = op[5] ? c_MEMWRITE : c_MEMREAD;
            end
            c_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) begin
                    w_next_state = c_MEMWB;
                end
            end
            c_MEMWB: begin
                result_src   = 2'b01;
                reg_write    = 1'b1;
                instr_done   = 1'b1;
                w_next_state = c_FETCH;
            end
            c_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    instr_done   = 1'b1;
                    w_next_state = c_FETCH;
                end
            end
            c_EXECUTER: begin
                alu_src_a    = 2'b10;
                alu_op       = 2'b10;
                w_next_state = c_ALUWB;
            end
            c_EXECUTEI: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                alu_op       = 2'b10;
                w_next_state = c_ALUWB;
            end
            c_ALUWB: begin
                reg_write    = 1'b1;
                instr_done   = 1'b1;
                w_next_state = c_FETCH;
            end
            c_BEQ: begin
                // Compare rs1 - rs2; target from DECODE sits in ALUOut.
                alu_src_a    = 2'b10;
                alu_op       = 2'b01;
                pc_write     = zero;
                instr_done   = 1'b1;
                w_next_state = c_FETCH;
            end
            c_JAL: begin
                // PC <- ALUOut (target); ALU computes OldPC+4 for rd.
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                pc_write     = 1'b1;
                w_next_state = c_ALUWB;
            end
            c_ERROR: begin
                illegal_op   = 1'b1;
                w_next_state = HALT_ON_ILLEGAL ? c_ERROR : c_FETCH;
            end
            default: begin
                // Unused encodings: drive nothing and recover.
                w_next_state = c_FETCH;
            end
        endcase

        // Reset forces every output low in the same cycle it is asserted.
        if (!rst_n) begin
            pc_write   = 1'b0;
            adr_src    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            result_src = 2'b00;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            reg_write  = 1'b0;
            imm_src    = 2'b00;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_multicycle_control_fsm
// Brief    : Self-checking bench for rv32i_multicycle_control_fsm. Each
//            instruction is expanded into its expected per-cycle control
//            word from the opcode class, memory wait counts and zero flag,
//            then replayed against the DUT. Instance a halts on illegal
//            opcodes, instance b returns to fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_multicycle_control_fsm;

    localparam logic [6:0] c_LOAD   = 7'b0000011;
    localparam logic [6:0] c_STORE  = 7'b0100011;
    localparam logic [6:0] c_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_BRANCH = 7'b1100011;
    localparam logic [6:0] c_JAL    = 7'b1101111;

    logic       clk = 1'b0;
    logic       rst_n_a, rst_n_b;
    logic [6:0] op;
    logic       zero, mem_ready;

    logic       a_pc_write, a_adr_src, a_mem_write, a_ir_write, a_reg_write;
    logic       a_instr_done, a_illegal_op;
    logic [1:0] a_result_src, a_alu_src_a, a_alu_src_b, a_alu_op, a_imm_src;
    logic       b_pc_write, b_adr_src, b_mem_write, b_ir_write, b_reg_write;
    logic       b_instr_done, b_illegal_op;
    logic [1:0] b_result_src, b_alu_src_a, b_alu_src_b, b_alu_op, b_imm_src;

    logic [16:0] w_out_a, w_out_b;

    int n_checks = 0;
    int n_errors = 0;
    int sel      = 0;   // 0: drive/check halting instance, 1: non-halting

    always #5 clk = ~clk;

    rv32i_multicycle_control_fsm #(.HALT_ON_ILLEGAL(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(a_pc_write), .adr_src(a_adr_src), .mem_write(a_mem_write),
        .ir_write(a_ir_write), .result_src(a_result_src), .alu_src_a(a_alu_src_a),
        .alu_src_b(a_alu_src_b), .alu_op(a_alu_op), .reg_write(a_reg_write),
        .imm_src(a_imm_src), .instr_done(a_instr_done), .illegal_op(a_illegal_op)
    );

    rv32i_multicycle_control_fsm #(.HALT_ON_ILLEGAL(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(b_pc_write), .adr_src(b_adr_src), .mem_write(b_mem_write),
        .ir_write(b_ir_write), .result_src(b_result_src), .alu_src_a(b_alu_src_a),
        .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .reg_write(b_reg_write),
        .imm_src(b_imm_src), .instr_done(b_instr_done), .illegal_op(b_illegal_op)
    );

    // Control word layout:
    // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
    //  alu_src_b, alu_op, reg_write, imm_src, instr_done, illegal_op}
    assign w_out_a = {a_pc_write, a_adr_src, a_mem_write, a_ir_write, a_result_src,
                      a_alu_src_a, a_alu_src_b, a_alu_op, a_reg_write, a_imm_src,
                      a_instr_done, a_illegal_op};
    assign w_out_b = {b_pc_write, b_adr_src, b_mem_write, b_ir_write, b_result_src,
                      b_alu_src_a, b_alu_src_b, b_alu_op, b_reg_write, b_imm_src,
                      b_instr_done, b_illegal_op};

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s op=%b got=%h exp=%h", tag, op, got, exp);
        end
    endtask

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == c_STORE)       return 2'b01;
        else if (o == c_BRANCH) return 2'b10;
        else if (o == c_JAL)    return 2'b11;
        else                    return 2'b00;
    endfunction

    function automatic logic [16:0] ov(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] ao, input logic rw,
                                       input logic dn, input logic il);
        return {pcw, adr, mw, irw, rs, sa, sb, ao, rw, imm_of(op), dn, il};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return (o == c_LOAD) || (o == c_STORE) || (o == c_RTYPE) ||
               (o == c_ITYPE) || (o == c_BRANCH) || (o == c_JAL);
    endfunction

    // One clock cycle: inputs change on the falling edge, outputs are
    // checked shortly after, well before the next rising edge.
    task automatic step(input logic rst, input logic mr, input logic z,
                        input logic [16:0] exp, input string tag);
        @(negedge clk);
        if (sel == 0) rst_n_a = rst;
        else          rst_n_b = rst;
        mem_ready = mr;
        zero      = z;
        #2;
        check(tag, (sel == 0) ? w_out_a : w_out_b, exp);
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++)
            step(1'b0, rbit(), rbit(), 17'h0, "reset");
    endtask

    task automatic do_fetch(input int waits);
        for (int i = 0; i < waits; i++)
            step(1'b1, 1'b0, rbit(), ov(0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,0,0), "fetch_wait");
        step(1'b1, 1'b1, rbit(), ov(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,0,0), "fetch");
    endtask

    // Expected cycle-by-cycle behaviour of one whole instruction.
    // fw: fetch waits, mw: memory waits, bz: zero flag in the branch cycle,
    // ec: error cycles observed before reset (halting instance only).
    task automatic run_instr(input logic [6:0] o, input int fw, input int mw,
                             input logic bz, input int ec);
        op = o;
        do_fetch(fw);
        step(1'b1, rbit(), rbit(), ov(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,0,0), "decode");
        if (o == c_LOAD || o == c_STORE) begin
            step(1'b1, rbit(), rbit(), ov(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0,0), "memadr");
            if (o == c_LOAD) begin
                for (int i = 0; i < mw; i++)
                    step(1'b1, 1'b0, rbit(), ov(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0), "memread_wait");
                step(1'b1, 1'b1, rbit(), ov(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0), "memread");
                step(1'b1, rbit(), rbit(), ov(0,0,0,0,2'b01,2'b00,2'b00,2'b00,1,1,0), "memwb");
            end else begin
                for (int i = 0; i < mw; i++)
                    step(1'b1, 1'b0, rbit(), ov(0,1,1,0,2'b00,2'b00,2'b00,2'b00,0,0,0), "memwrite_wait");
                step(1'b1, 1'b1, rbit(), ov(0,1,1,0,2'b00,2'b00,2'b00,2'b00,0,1,0), "memwrite");
            end
        end else if (o == c_RTYPE || o == c_ITYPE) begin
            step(1'b1, rbit(), rbit(),
                 ov(0,0,0,0,2'b00,2'b10,(o == c_ITYPE) ? 2'b01 : 2'b00,2'b10,0,0,0), "execute");
            step(1'b1, rbit(), rbit(), ov(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,1,0), "aluwb");
        end else if (o == c_BRANCH) begin
            step(1'b1, rbit(), bz, ov(bz,0,0,0,2'b00,2'b10,2'b00,2'b01,0,1,0), "beq");
        end else if (o == c_JAL) begin
            step(1'b1, rbit(), rbit(), ov(1,0,0,0,2'b00,2'b01,2'b10,2'b00,0,0,0), "jal");
            step(1'b1, rbit(), rbit(), ov(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,1,0), "jal_wb");
        end else if (sel == 0) begin
            for (int i = 0; i < ec; i++)
                step(1'b1, rbit(), rbit(), ov(0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,1), "error_halt");
            do_reset(1);
        end else begin
            step(1'b1, rbit(), rbit(), ov(0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,1), "error_pulse");
        end
    endtask

    function automatic logic [6:0] rand_illegal();
        logic [6:0] o;
        o = 7'($urandom);
        while (is_legal(o)) o = 7'($urandom);
        return o;
    endfunction

    function automatic logic [6:0] rand_op();
        case ($urandom_range(0, 12))
            0, 1:    return c_LOAD;
            2, 3:    return c_STORE;
            4, 5:    return c_RTYPE;
            6, 7:    return c_ITYPE;
            8, 9:    return c_BRANCH;
            10, 11:  return c_JAL;
            default: return rand_illegal();
        endcase
    endfunction

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++)
            run_instr(rand_op(), $urandom_range(0, 2), $urandom_range(0, 3),
                      rbit(), $urandom_range(1, 4));
    endtask

    initial begin
        rst_n_a   = 1'b0;
        rst_n_b   = 1'b0;
        op        = c_ITYPE;
        zero      = 1'b0;
        mem_ready = 1'b0;

        // Halting instance
        sel = 0;
        do_reset(2);
        run_instr(c_LOAD, 0, 0, 1'b0, 0);
        run_instr(c_STORE, 0, 2, 1'b0, 0);
        run_instr(c_RTYPE, 0, 0, 1'b0, 0);
        run_instr(c_ITYPE, 0, 0, 1'b0, 0);
        run_instr(c_BRANCH, 0, 0, 1'b1, 0);
        run_instr(c_BRANCH, 0, 0, 1'b0, 0);
        run_instr(c_JAL, 1, 0, 1'b0, 0);

        // Reset in the middle of a stalled store
        op = c_STORE;
        do_fetch(0);
        step(1'b1, 1'b1, 1'b0, ov(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,0,0), "decode");
        step(1'b1, 1'b1, 1'b0, ov(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0,0), "memadr");
        step(1'b1, 1'b0, 1'b0, ov(0,1,1,0,2'b00,2'b00,2'b00,2'b00,0,0,0), "memwrite_wait");
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'b0, 1'b0, 17'h0, "reset_mid_store");
        run_instr(c_LOAD, 1, 1, 1'b0, 0);

        // Illegal opcode: sticky for 10 cycles, cleared by reset
        run_instr(7'b1111111, 0, 0, 1'b0, 10);
        run_instr(c_RTYPE, 0, 0, 1'b0, 0);

        random_run(150);

        // Non-halting instance
        rst_n_a = 1'b0;
        sel     = 1;
        do_reset(2);
        run_instr(7'b1111111, 0, 0, 1'b0, 0);
        run_instr(c_LOAD, 0, 0, 1'b0, 0);
        random_run(60);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
